// File: rtl/cg_pkg.sv
// Shared types and default widths for the pixel-region clock-gate enable controller.
package cg_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } cg_state_t;

  localparam int CG_CNT_W    = 6;
  localparam int CG_IDLE_W   = 8;
  localparam int GATED_CNT_W = 16;
  localparam int WAKE_CNT_W  = 4;

endpackage

// File: rtl/cg_hit_counter.sv
// Saturating up/down count of outstanding hits with a sticky over/underflow flag.
module cg_hit_counter
  import cg_pkg::*;
#(
  parameter int CNT_W = CG_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) err_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt = cnt_q;
  assign err = err_q;

endmodule

// File: rtl/cg_enable_ctrl.sv
// Clock-gate Enable generator: OFF/WAKE/ON/IDLE FSM on the ungated region clock.
// Optional gated-cycle statistics counter is built when CG_STATS_EN is defined.
module cg_enable_ctrl
  import cg_pkg::*;
#(
  parameter int CNT_W       = CG_CNT_W,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_W      = CG_IDLE_W
) (
  input  logic                   ClkIn,
  input  logic                   Reset,
  input  logic                   HitIn,
  input  logic                   HitDone,
  input  logic                   ReadReq,
  input  logic                   ForceOn,
  input  logic [IDLE_W-1:0]      IdleThr,
  output logic                   Enable,
  output logic                   ClkReady,
  output logic [CNT_W-1:0]       HitCnt,
  output logic                   CntErr,
  output logic [GATED_CNT_W-1:0] GatedCycles
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_LOAD = WAKE_CNT_W'(WAKE_CYCLES - 1);

  cg_state_t             state_q, state_d;
  logic                  enable_q, enable_d;
  logic                  clk_ready_q, clk_ready_d;
  logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                  busy;

  cg_hit_counter #(
    .CNT_W (CNT_W)
  ) u_hit_counter (
    .clk (ClkIn),
    .rst (Reset),
    .inc (HitIn),
    .dec (HitDone),
    .cnt (HitCnt),
    .err (CntErr)
  );

  // A live HitIn counts as busy, so IDLE can never gate off in the cycle a hit lands.
  assign busy = HitIn | ReadReq | ForceOn | (HitCnt != '0);

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_OFF: begin
        if (busy) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q == '0) state_d = ST_ON;
        else                  wake_cnt_d = wake_cnt_q - 1'b1;
      end
      ST_ON: begin
        if (!busy) begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end
      end
      ST_IDLE: begin
        if (busy) begin
          state_d    = ST_ON;
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= IdleThr) begin
          state_d = ST_OFF;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Outputs are decoded from the next state so they land together with it.
  always_comb begin
    enable_d    = (state_d != ST_OFF);
    clk_ready_d = (state_d == ST_ON) || (state_d == ST_IDLE);
  end

  always_ff @(posedge ClkIn) begin
    if (Reset) begin
      state_q     <= ST_OFF;
      enable_q    <= 1'b0;
      clk_ready_q <= 1'b0;
      wake_cnt_q  <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= enable_d;
      clk_ready_q <= clk_ready_d;
      wake_cnt_q  <= wake_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign Enable   = enable_q;
  assign ClkReady = clk_ready_q;

`ifdef CG_STATS_EN
  logic [GATED_CNT_W-1:0] gated_q, gated_d;

  always_comb begin
    gated_d = gated_q;
    if (!enable_q && (gated_q != '1)) gated_d = gated_q + 1'b1;
  end

  always_ff @(posedge ClkIn) begin
    if (Reset) gated_q <= '0;
    else       gated_q <= gated_d;
  end

  assign GatedCycles = gated_q;
`else
  assign GatedCycles = '0;
`endif

endmodule

// File: tb/tb_cg_enable_ctrl.sv
// Directed bench for cg_enable_ctrl: vector table plus hand-written corner sequences.
module tb_cg_enable_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hit, done, rd, frc;
  logic [7:0]  thr;
  logic        en, rdy, err;
  logic [5:0]  cnt;
  logic [15:0] gated;

  logic        hit2, done2;
  logic        en2, rdy2, err2;
  logic [1:0]  cnt2;
  logic [15:0] gated2;
  logic        zero;
  logic [7:0]  thr2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cg_enable_ctrl #(.CNT_W(6), .WAKE_CYCLES(2), .IDLE_W(8)) dut (
    .ClkIn(clk), .Reset(rst), .HitIn(hit), .HitDone(done), .ReadReq(rd),
    .ForceOn(frc), .IdleThr(thr), .Enable(en), .ClkReady(rdy), .HitCnt(cnt),
    .CntErr(err), .GatedCycles(gated)
  );

  cg_enable_ctrl #(.CNT_W(2), .WAKE_CYCLES(2), .IDLE_W(8)) dut2 (
    .ClkIn(clk), .Reset(rst), .HitIn(hit2), .HitDone(done2), .ReadReq(zero),
    .ForceOn(zero), .IdleThr(thr2), .Enable(en2), .ClkReady(rdy2), .HitCnt(cnt2),
    .CntErr(err2), .GatedCycles(gated2)
  );

  typedef struct {
    logic       hit, done, rd, frc;
    logic [7:0] thr;
    logic       en, rdy;
    logic [5:0] cnt;
  } vec_t;

  vec_t vecs[$];

`ifdef CG_STATS_EN
  localparam int EXP_GATED = 50;
`else
  localparam int EXP_GATED = 0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic h, input logic d, input logic r, input logic f,
                     input logic [7:0] t, input logic e, input logic y, input logic [5:0] c);
    vec_t v;
    v.hit = h; v.done = d; v.rd = r; v.frc = f; v.thr = t;
    v.en = e; v.rdy = y; v.cnt = c;
    vecs.push_back(v);
  endtask

  initial begin
    // single hit, wake of two cycles, drain, five idle cycles at IdleThr=4
    add(1,0,0,0,4, 1,0,1);
    add(0,0,0,0,4, 1,0,1);
    add(0,0,0,0,4, 1,1,1);
    add(0,0,0,0,4, 1,1,1);
    add(0,0,0,0,4, 1,1,1);
    add(0,1,0,0,4, 1,1,0);
    for (int k = 0; k < 5; k++) add(0,0,0,0,4, 1,1,0);
    add(0,0,0,0,4, 0,0,0);
    add(0,0,0,0,4, 0,0,0);
    // count to 3, simultaneous hit+done, drain, re-wake from IDLE at idle count 3
    add(1,0,0,0,4, 1,0,1);
    add(1,0,0,0,4, 1,0,2);
    add(1,0,0,0,4, 1,1,3);
    add(1,1,0,0,4, 1,1,3);
    add(1,1,0,0,4, 1,1,3);
    add(0,1,0,0,4, 1,1,2);
    add(0,1,0,0,4, 1,1,1);
    add(0,1,0,0,4, 1,1,0);
    for (int k = 0; k < 4; k++) add(0,0,0,0,4, 1,1,0);
    add(1,0,0,0,4, 1,1,1);
    add(0,1,0,0,4, 1,1,0);
    for (int k = 0; k < 5; k++) add(0,0,0,0,4, 1,1,0);
    add(0,0,0,0,4, 0,0,0);
    // one-cycle ReadReq still completes the wake; IdleThr=0 gates after one IDLE cycle
    add(0,0,1,0,4, 1,0,0);
    add(0,0,0,0,4, 1,0,0);
    add(0,0,0,0,4, 1,1,0);
    add(0,0,0,0,0, 1,1,0);
    add(0,0,0,0,0, 0,0,0);
    // hit at the idle threshold keeps the clock on
    add(1,0,0,0,1, 1,0,1);
    add(0,1,0,0,1, 1,0,0);
    add(0,0,0,0,1, 1,1,0);
    add(0,0,0,0,1, 1,1,0);
    add(0,0,0,0,1, 1,1,0);
    add(1,0,0,0,1, 1,1,1);
    add(0,1,0,0,1, 1,1,0);
    add(0,0,0,0,1, 1,1,0);
    add(0,0,0,0,1, 1,1,0);
    add(0,0,0,0,1, 0,0,0);

    rst = 1'b1; hit = 0; done = 0; rd = 0; frc = 0; thr = 8'd4;
    hit2 = 0; done2 = 0; zero = 0; thr2 = 8'd4;
    repeat (3) step();
    check("rst_en", int'(en), 0);
    check("rst_rdy", int'(rdy), 0);
    check("rst_cnt", int'(cnt), 0);
    check("rst_err", int'(err), 0);
    check("rst_gated", int'(gated), 0);
    check("rst_cnt2", int'(cnt2), 0);

    rst = 1'b0;
    repeat (50) step();
    check("gated50", int'(gated), EXP_GATED);
    check("gated50_en", int'(en), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      hit = vecs[i].hit; done = vecs[i].done; rd = vecs[i].rd;
      frc = vecs[i].frc; thr = vecs[i].thr;
      step();
      check($sformatf("vec%0d_en", i), int'(en), int'(vecs[i].en));
      check($sformatf("vec%0d_rdy", i), int'(rdy), int'(vecs[i].rdy));
      check($sformatf("vec%0d_cnt", i), int'(cnt), int'(vecs[i].cnt));
    end
    hit = 0; done = 0; rd = 0; frc = 0;
    check("table_err", int'(err), 0);

    // ForceOn held with no hits, then released with IdleThr=0
    thr = 8'd4; frc = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      check($sformatf("force%0d_en", k), int'(en), 1);
    end
    check("force_rdy", int'(rdy), 1);
    frc = 1'b0; thr = 8'd0;
    step();
    check("release1_en", int'(en), 1);
    step();
    check("release2_en", int'(en), 0);
    check("release2_rdy", int'(rdy), 0);

    // Reset while ON with a nonzero count
    thr = 8'd4; hit = 1'b1;
    step();
    hit = 1'b0;
    repeat (2) step();
    check("pre_rst_rdy", int'(rdy), 1);
    check("pre_rst_cnt", int'(cnt), 1);
    rst = 1'b1;
    step();
    check("midrst_en", int'(en), 0);
    check("midrst_rdy", int'(rdy), 0);
    check("midrst_cnt", int'(cnt), 0);
    check("midrst_gated", int'(gated), 0);
    rst = 1'b0;
    step();

    // 2-bit counter saturation and underflow
    for (int k = 0; k < 3; k++) begin
      hit2 = 1'b1; step(); hit2 = 1'b0; step();
    end
    check("sat3_cnt", int'(cnt2), 3);
    check("sat3_err", int'(err2), 0);
    hit2 = 1'b1; step(); hit2 = 1'b0; step();
    check("sat4_cnt", int'(cnt2), 3);
    check("sat4_err", int'(err2), 1);
    for (int k = 0; k < 5; k++) begin
      done2 = 1'b1; step(); done2 = 1'b0; step();
    end
    check("under_cnt", int'(cnt2), 0);
    check("under_err", int'(err2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
